// File: rtl/cam_reg_write_sequencer_pkg.sv
// Shared constants for the camera register write sequencer: opcodes, FSM
// encoding, register-triple counts and the byte-within-triple selector.
package cam_reg_write_sequencer_pkg;

    localparam logic [7:0] OP_TRIGGER = 8'h01;
    localparam logic [7:0] OP_SHUTTER = 8'h03;
    localparam logic [7:0] OP_WINDOW  = 8'h05;
    localparam logic [7:0] OP_SRESET  = 8'h0B;
    localparam logic [7:0] OP_RAW     = 8'h0C;

    localparam logic [2:0] CNT_SHUTTER = 3'd7;
    localparam logic [2:0] CNT_WINDOW  = 3'd4;
    localparam logic [2:0] CNT_SRESET  = 3'd1;
    localparam logic [2:0] CNT_RAW     = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Byte 0 of a triple is the register address, then data high, data low.
    function automatic logic [7:0] triple_byte(input logic [7:0]  reg_addr,
                                               input logic [15:0] word,
                                               input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = reg_addr;
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cam_reg_word_map.sv
// Combinational map from (opcode, triple index, command payload) to the
// register address / 16-bit value written by that triple.
module cam_reg_word_map
    import cam_reg_write_sequencer_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [2:0]  i_triple,
    input  logic [63:0] i_data,
    output logic [7:0]  o_reg,
    output logic [15:0] o_word,
    output logic [2:0]  o_count,
    output logic        o_is_write
);

    logic w_unused;
    assign w_unused = i_data[63];

    // Register/value table per opcode; unknown opcodes report no triples.
    always_comb begin
        o_reg      = 8'h00;
        o_word     = 16'h0000;
        o_count    = 3'd0;
        o_is_write = 1'b0;
        case (i_op)
            OP_SHUTTER: begin
                o_count    = CNT_SHUTTER;
                o_is_write = 1'b1;
                case (i_triple)
                    3'd0:    begin o_reg = 8'h08; o_word = {12'h000, i_data[22:19]};          end
                    3'd1:    begin o_reg = 8'h09; o_word = i_data[18:3];                      end
                    3'd2:    begin o_reg = 8'h0C; o_word = {3'b000, i_data[35:23]};           end
                    3'd3:    begin o_reg = 8'h22; o_word = {10'h000, i_data[37:36], 4'h0};    end
                    3'd4:    begin o_reg = 8'h23; o_word = {10'h000, i_data[39:38], 4'h0};    end
                    3'd5:    begin o_reg = 8'h05; o_word = {4'h0, i_data[51:40]};             end
                    3'd6:    begin o_reg = 8'h06; o_word = {5'b00000, i_data[62:52]};         end
                    default: begin o_reg = 8'h00; o_word = 16'h0000;                          end
                endcase
            end
            OP_WINDOW: begin
                o_count    = CNT_WINDOW;
                o_is_write = 1'b1;
                case (i_triple)
                    3'd0:    begin o_reg = 8'h01; o_word = {5'b00000, i_data[10:0]};  end
                    3'd1:    begin o_reg = 8'h02; o_word = {4'h0, i_data[22:11]};     end
                    3'd2:    begin o_reg = 8'h03; o_word = {5'b00000, i_data[33:23]}; end
                    3'd3:    begin o_reg = 8'h04; o_word = {4'h0, i_data[45:34]};     end
                    default: begin o_reg = 8'h00; o_word = 16'h0000;                  end
                endcase
            end
            OP_SRESET: begin
                o_count    = CNT_SRESET;
                o_is_write = 1'b1;
                o_reg      = 8'h0D;
                o_word     = {15'h0000, i_data[1]};
            end
            OP_RAW: begin
                o_count    = CNT_RAW;
                o_is_write = 1'b1;
                o_reg      = i_data[7:0];
                o_word     = i_data[23:8];
            end
            default: begin
                o_count    = 3'd0;
                o_is_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cam_reg_write_sequencer.sv
// Turns camera commands into I2C register-write byte triples, handles trigger
// capture commands and keeps per-camera compression/RGB configuration.
module cam_reg_write_sequencer
    import cam_reg_write_sequencer_pkg::*;
#(
    parameter int NUM_CAMS   = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  sysClk,
    input  logic                  sysRst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_addr,
    input  logic [63:0]           cmd_data,
    input  logic [1:0]            cmd_cam,
    output logic [7:0]            i2c_byte,
    output logic                  i2c_valid,
    input  logic                  i2c_ready,
    output logic                  i2c_first,
    output logic                  i2c_last,
    output logic [1:0]            cam_sel,
    output logic                  trigger,
    output logic [15:0]           trigger_index,
    output logic [27:0]           timestamp,
    output logic [2*NUM_CAMS-1:0] compression,
    output logic [NUM_CAMS-1:0]   rgb,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] NUM_CAMS_W = 3'(NUM_CAMS);
    localparam bit         HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [7:0] GAP_LAST   = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t                r_state;
    logic [7:0]            r_op;
    logic [63:0]           r_data;
    logic [2:0]            r_triple;
    logic [2:0]            r_count;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_gap;
    logic [7:0]            r_i2c_byte;
    logic                  r_i2c_valid;
    logic                  r_i2c_first;
    logic                  r_i2c_last;
    logic [1:0]            r_cam_sel;
    logic                  r_trigger;
    logic [15:0]           r_trigger_index;
    logic [27:0]           r_timestamp;
    logic [2*NUM_CAMS-1:0] r_compression;
    logic [NUM_CAMS-1:0]   r_rgb;
    logic                  r_done;
    logic                  r_err;

    logic [7:0]  w_sel_op;
    logic [63:0] w_sel_data;
    logic [2:0]  w_sel_triple;
    logic [1:0]  w_sel_idx;
    logic [7:0]  w_map_reg;
    logic [15:0] w_map_word;
    logic [2:0]  w_map_count;
    logic        w_map_is_write;
    logic [7:0]  w_next_byte;
    logic        w_cam_ok;
    logic        w_hs;

    assign w_cam_ok = ({1'b0, cmd_cam} < NUM_CAMS_W);
    assign w_hs     = r_i2c_valid && i2c_ready;

    // Select which triple/byte the map should produce for the next output load.
    always_comb begin
        w_sel_op     = r_op;
        w_sel_data   = r_data;
        w_sel_triple = r_triple;
        w_sel_idx    = 2'd0;
        if (r_state == ST_IDLE) begin
            w_sel_op     = cmd_addr;
            w_sel_data   = cmd_data;
            w_sel_triple = 3'd0;
        end else if (r_state == ST_EMIT) begin
            if (r_byte_idx == 2'd2) begin
                w_sel_triple = r_triple + 3'd1;
            end else begin
                w_sel_idx = r_byte_idx + 2'd1;
            end
        end else begin
            w_sel_idx = 2'd0;
        end
    end

    cam_reg_word_map u_word_map (
        .i_op       (w_sel_op),
        .i_triple   (w_sel_triple),
        .i_data     (w_sel_data),
        .o_reg      (w_map_reg),
        .o_word     (w_map_word),
        .o_count    (w_map_count),
        .o_is_write (w_map_is_write)
    );

    assign w_next_byte = triple_byte(w_map_reg, w_map_word, w_sel_idx);

    // Command FSM, byte/triple/gap counters and all registered outputs.
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            r_state         <= ST_IDLE;
            r_op            <= 8'h00;
            r_data          <= 64'h0;
            r_triple        <= 3'd0;
            r_count         <= 3'd0;
            r_byte_idx      <= 2'd0;
            r_gap           <= 8'd0;
            r_i2c_byte      <= 8'h00;
            r_i2c_valid     <= 1'b0;
            r_i2c_first     <= 1'b0;
            r_i2c_last      <= 1'b0;
            r_cam_sel       <= 2'd0;
            r_trigger       <= 1'b0;
            r_trigger_index <= 16'h0000;
            r_timestamp     <= 28'h0;
            r_compression   <= '0;
            r_rgb           <= '0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_trigger <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_addr;
                        r_data <= cmd_data;
                        if (!w_cam_ok || (!w_map_is_write && cmd_addr != OP_TRIGGER)) begin
                            r_err <= 1'b1;
                        end else if (cmd_addr == OP_TRIGGER) begin
                            r_trigger       <= 1'b1;
                            r_done          <= 1'b1;
                            r_cam_sel       <= cmd_cam;
                            r_trigger_index <= cmd_data[16:1];
                            r_timestamp     <= cmd_data[44:17];
                        end else begin
                            r_state     <= ST_EMIT;
                            r_cam_sel   <= cmd_cam;
                            r_count     <= w_map_count;
                            r_triple    <= 3'd0;
                            r_byte_idx  <= 2'd0;
                            r_i2c_valid <= 1'b1;
                            r_i2c_byte  <= w_next_byte;
                            r_i2c_first <= 1'b1;
                            r_i2c_last  <= 1'b0;
                            if (cmd_addr == OP_SHUTTER) begin
                                for (int k = 0; k < NUM_CAMS; k++) begin
                                    if (cmd_cam == 2'(k)) begin
                                        r_compression[2*k +: 2] <= cmd_data[1:0];
                                        r_rgb[k]                <= cmd_data[2];
                                    end
                                end
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_hs) begin
                        if (r_byte_idx != 2'd2) begin
                            r_byte_idx  <= r_byte_idx + 2'd1;
                            r_i2c_byte  <= w_next_byte;
                            r_i2c_first <= 1'b0;
                            r_i2c_last  <= (r_byte_idx == 2'd1);
                        end else if (r_triple == r_count - 3'd1) begin
                            r_state     <= ST_FINISH;
                            r_i2c_valid <= 1'b0;
                            r_i2c_first <= 1'b0;
                            r_i2c_last  <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_triple   <= r_triple + 3'd1;
                            r_byte_idx <= 2'd0;
                            r_i2c_last <= 1'b0;
                            if (HAS_GAP) begin
                                r_state     <= ST_GAP;
                                r_gap       <= 8'd0;
                                r_i2c_valid <= 1'b0;
                                r_i2c_first <= 1'b0;
                            end else begin
                                r_i2c_byte  <= w_next_byte;
                                r_i2c_first <= 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state     <= ST_EMIT;
                        r_i2c_valid <= 1'b1;
                        r_i2c_byte  <= w_next_byte;
                        r_i2c_first <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_i2c_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign i2c_byte      = r_i2c_byte;
    assign i2c_valid     = r_i2c_valid;
    assign i2c_first     = r_i2c_first;
    assign i2c_last      = r_i2c_last;
    assign cam_sel       = r_cam_sel;
    assign trigger       = r_trigger;
    assign trigger_index = r_trigger_index;
    assign timestamp     = r_timestamp;
    assign compression   = r_compression;
    assign rgb           = r_rgb;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_cam_reg_write_sequencer.sv
// Scoreboard bench: expected bytes are queued per instance when a command is
// driven and compared as each byte is taken from the I2C side.
module tb_cam_reg_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid[2];
    logic        cmd_ready[2];
    logic [7:0]  cmd_addr[2];
    logic [63:0] cmd_data[2];
    logic [1:0]  cmd_cam[2];
    logic [7:0]  i2c_byte[2];
    logic        i2c_valid[2];
    logic        i2c_ready[2];
    logic        i2c_first[2];
    logic        i2c_last[2];
    logic [1:0]  cam_sel[2];
    logic        trigger[2];
    logic [15:0] trigger_index[2];
    logic [27:0] timestamp[2];
    logic [3:0]  compression[2];
    logic [1:0]  rgb[2];
    logic        done[2];
    logic        err[2];

    cam_reg_write_sequencer #(.NUM_CAMS(2), .GAP_CYCLES(0)) dut0 (
        .sysClk(clk), .sysRst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_addr(cmd_addr[0]),
        .cmd_data(cmd_data[0]), .cmd_cam(cmd_cam[0]),
        .i2c_byte(i2c_byte[0]), .i2c_valid(i2c_valid[0]), .i2c_ready(i2c_ready[0]),
        .i2c_first(i2c_first[0]), .i2c_last(i2c_last[0]), .cam_sel(cam_sel[0]),
        .trigger(trigger[0]), .trigger_index(trigger_index[0]), .timestamp(timestamp[0]),
        .compression(compression[0]), .rgb(rgb[0]), .done(done[0]), .err(err[0])
    );

    cam_reg_write_sequencer #(.NUM_CAMS(2), .GAP_CYCLES(3)) dut1 (
        .sysClk(clk), .sysRst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_addr(cmd_addr[1]),
        .cmd_data(cmd_data[1]), .cmd_cam(cmd_cam[1]),
        .i2c_byte(i2c_byte[1]), .i2c_valid(i2c_valid[1]), .i2c_ready(i2c_ready[1]),
        .i2c_first(i2c_first[1]), .i2c_last(i2c_last[1]), .cam_sel(cam_sel[1]),
        .trigger(trigger[1]), .trigger_index(trigger_index[1]), .timestamp(timestamp[1]),
        .compression(compression[1]), .rgb(rgb[1]), .done(done[1]), .err(err[1])
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc_n = 0;
    int acc_cyc = 0;
    int hs_cnt[2]    = '{0, 0};
    int first_cnt[2] = '{0, 0};
    int done_cnt[2]  = '{0, 0};
    int done_cyc[2]  = '{0, 0};
    int err_cnt[2]   = '{0, 0};
    int trig_cnt[2]  = '{0, 0};
    int trig_cyc[2]  = '{0, 0};
    bit pend[2]      = '{1'b0, 1'b0};
    logic [11:0] held[2];
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    bit gap_meas = 1'b0;
    bit in_gap = 1'b0;
    int gap_len = 0;
    int gap_log[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_triple(input int u, input logic [1:0] cam, input logic [7:0] ra, input logic [15:0] w);
        if (u == 0) begin
            q0.push_back({cam, 2'b10, ra});
            q0.push_back({cam, 2'b00, w[15:8]});
            q0.push_back({cam, 2'b01, w[7:0]});
        end else begin
            q1.push_back({cam, 2'b10, ra});
            q1.push_back({cam, 2'b00, w[15:8]});
            q1.push_back({cam, 2'b01, w[7:0]});
        end
    endtask

    task automatic push_cmd(input int u, input logic [7:0] op, input logic [63:0] d, input logic [1:0] cam);
        case (op)
            8'h03: begin
                push_triple(u, cam, 8'h08, {12'h000, d[22:19]});
                push_triple(u, cam, 8'h09, d[18:3]);
                push_triple(u, cam, 8'h0C, {3'b000, d[35:23]});
                push_triple(u, cam, 8'h22, {10'h000, d[37:36], 4'h0});
                push_triple(u, cam, 8'h23, {10'h000, d[39:38], 4'h0});
                push_triple(u, cam, 8'h05, {4'h0, d[51:40]});
                push_triple(u, cam, 8'h06, {5'b00000, d[62:52]});
            end
            8'h05: begin
                push_triple(u, cam, 8'h01, {5'b00000, d[10:0]});
                push_triple(u, cam, 8'h02, {4'h0, d[22:11]});
                push_triple(u, cam, 8'h03, {5'b00000, d[33:23]});
                push_triple(u, cam, 8'h04, {4'h0, d[45:34]});
            end
            8'h0B:   push_triple(u, cam, 8'h0D, {15'h0000, d[1]});
            8'h0C:   push_triple(u, cam, d[7:0], d[23:8]);
            default: ;
        endcase
    endtask

    task automatic mon(input int u);
        logic [11:0] cur;
        logic [11:0] e;
        cur = {cam_sel[u], i2c_first[u], i2c_last[u], i2c_byte[u]};
        if (done[u]) begin done_cnt[u]++; done_cyc[u] = cyc_n; end
        if (err[u]) err_cnt[u]++;
        if (trigger[u]) begin trig_cnt[u]++; trig_cyc[u] = cyc_n; end
        if (i2c_valid[u]) begin
            if (u == 1 && in_gap) begin gap_log.push_back(gap_len); in_gap = 1'b0; end
            if (pend[u]) check_val("hold", {52'h0, cur}, {52'h0, held[u]});
            if (i2c_ready[u]) begin
                hs_cnt[u]++;
                if (i2c_first[u]) first_cnt[u]++;
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    check_val("sb_empty", {52'h0, cur}, 64'hFFFF_FFFF);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    check_val("byte", {52'h0, cur}, {52'h0, e});
                end
                pend[u] = 1'b0;
                if (u == 1 && gap_meas && i2c_last[1]) begin in_gap = 1'b1; gap_len = 0; end
            end else begin
                pend[u] = 1'b1;
                held[u] = cur;
            end
        end else begin
            if (pend[u]) check_val("hold_valid", {63'h0, i2c_valid[u]}, 64'h1);
            pend[u] = 1'b0;
            if (u == 1 && in_gap) gap_len++;
        end
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic send(input int u, input logic [7:0] op, input logic [63:0] d, input logic [1:0] cam);
        int t;
        t = 0;
        while (cmd_ready[u] !== 1'b1 && t < 100) begin cyc(); t++; end
        if (t >= 100) check_val("ready_timeout", {63'h0, cmd_ready[u]}, 64'h1);
        cmd_valid[u] = 1'b1;
        cmd_addr[u]  = op;
        cmd_data[u]  = d;
        cmd_cam[u]   = cam;
        cyc();
        acc_cyc = cyc_n - 1;
        cmd_valid[u] = 1'b0;
        cmd_addr[u]  = 8'h0C;
        cmd_data[u]  = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int u, input int budget, input bit tog);
        int d0;
        int t;
        d0 = done_cnt[u];
        t = 0;
        while (done_cnt[u] == d0 && t < budget) begin
            cyc();
            if (tog) i2c_ready[u] = ~i2c_ready[u];
            t++;
        end
        if (done_cnt[u] == d0) check_val("done_timeout", 64'(done_cnt[u]), 64'(d0 + 1));
    endtask

    initial begin
        int hs0;
        int f0;
        int t0;
        int d0;
        int e0;
        logic [63:0] d;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0; cmd_addr[u] = 8'h00; cmd_data[u] = 64'h0;
            cmd_cam[u] = 2'd0; i2c_ready[u] = 1'b1;
        end
        repeat (3) cyc();
        check_val("rst_outs", {44'h0, i2c_byte[0], i2c_valid[0], i2c_first[0], i2c_last[0], cam_sel[0],
                               trigger[0], compression[0], rgb[0], done[0], err[0]}, 64'h0);
        check_val("rst_trig_regs", {20'h0, trigger_index[0], timestamp[0]}, 64'h0);
        check_val("rst_ready", {63'h0, cmd_ready[0]}, 64'h1);
        rst_n = 1'b1;
        cyc();
        check_val("ready_after_rst", {63'h0, cmd_ready[0]}, 64'h1);

        // Shutter, cam 1, full-speed stream
        d = 64'h7FFF_FFFF_FFFF_FFFF;
        hs0 = hs_cnt[0];
        push_cmd(0, 8'h03, d, 2'd1);
        send(0, 8'h03, d, 2'd1);
        wait_done(0, 60, 1'b0);
        check_val("shutter_done_lat", 64'(done_cyc[0] - acc_cyc), 64'd22);
        check_val("shutter_bytes", 64'(hs_cnt[0] - hs0), 64'd21);
        check_val("shutter_comp", {60'h0, compression[0]}, 64'hC);
        check_val("shutter_rgb", {62'h0, rgb[0]}, 64'h2);

        // Window with ready toggling every cycle
        d = 64'h0123_4567_89AB_CDEF;
        hs0 = hs_cnt[0];
        f0 = first_cnt[0];
        push_cmd(0, 8'h05, d, 2'd0);
        send(0, 8'h05, d, 2'd0);
        wait_done(0, 100, 1'b1);
        i2c_ready[0] = 1'b1;
        check_val("window_bytes", 64'(hs_cnt[0] - hs0), 64'd12);
        check_val("window_firsts", 64'(first_cnt[0] - f0), 64'd4);
        check_val("window_sb", 64'(q0.size()), 64'd0);

        // Gap instance: sensor reset then window
        d = 64'h0000_0000_0000_0002;
        push_cmd(1, 8'h0B, d, 2'd1);
        send(1, 8'h0B, d, 2'd1);
        wait_done(1, 40, 1'b0);
        d = 64'h0000_3A5C_96F0_1E2D;
        gap_meas = 1'b1;
        push_cmd(1, 8'h05, d, 2'd0);
        send(1, 8'h05, d, 2'd0);
        wait_done(1, 100, 1'b0);
        gap_meas = 1'b0;
        in_gap = 1'b0;
        check_val("gap_count", 64'(gap_log.size()), 64'd3);
        foreach (gap_log[i]) check_val("gap_len", 64'(gap_log[i]), 64'd3);
        check_val("gap_sb", 64'(q1.size()), 64'd0);

        // Trigger on cam 1
        d = {19'h0, 28'hABCDEF0, 16'h1234, 1'b0};
        hs0 = hs_cnt[0];
        t0 = trig_cnt[0];
        d0 = done_cnt[0];
        send(0, 8'h01, d, 2'd1);
        repeat (4) cyc();
        check_val("trig_pulses", 64'(trig_cnt[0] - t0), 64'd1);
        check_val("trig_cycle", 64'(trig_cyc[0] - acc_cyc), 64'd1);
        check_val("trig_done", 64'(done_cnt[0] - d0), 64'd1);
        check_val("trig_index", {48'h0, trigger_index[0]}, 64'h1234);
        check_val("trig_ts", {36'h0, timestamp[0]}, 64'hABCDEF0);
        check_val("trig_cam", {62'h0, cam_sel[0]}, 64'd1);
        check_val("trig_no_bytes", 64'(hs_cnt[0] - hs0), 64'd0);

        // Rejected commands: unknown opcode, then out-of-range camera
        hs0 = hs_cnt[0];
        e0 = err_cnt[0];
        send(0, 8'h07, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
        send(0, 8'h03, 64'h0000_0000_0000_0000, 2'd3);
        repeat (4) cyc();
        check_val("err_pulses", 64'(err_cnt[0] - e0), 64'd2);
        check_val("err_no_bytes", 64'(hs_cnt[0] - hs0), 64'd0);
        check_val("err_comp", {60'h0, compression[0]}, 64'hC);
        check_val("err_rgb", {62'h0, rgb[0]}, 64'h2);
        check_val("err_idx", {48'h0, trigger_index[0]}, 64'h1234);

        // Reset asserted while byte 5 of a shutter is on the bus
        d = 64'h1357_9BDF_2468_ACE0;
        hs0 = hs_cnt[0];
        push_cmd(0, 8'h03, d, 2'd0);
        send(0, 8'h03, d, 2'd0);
        t0 = 0;
        while (hs_cnt[0] - hs0 < 4 && t0 < 50) begin cyc(); t0++; end
        check_val("rst_mid_reach", 64'(hs_cnt[0] - hs0), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", {63'h0, i2c_valid[0]}, 64'h0);
        q0.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check_val("rst_mid_ready", {63'h0, cmd_ready[0]}, 64'h1);
        repeat (30) cyc();
        check_val("rst_mid_no_resume", 64'(hs_cnt[0] - hs0), 64'd4);
        check_val("rst_mid_comp", {60'h0, compression[0]}, 64'h0);

        check_val("final_sb0", 64'(q0.size()), 64'd0);
        check_val("final_sb1", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
